// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS receive channel: control tokens and alignment states.
// Bit order: sym[0] is the first bit on the wire; the next symbol's bit 0 follows sym[9].
package tmds_pkg;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    typedef enum logic [1:0] {
        SEARCH,
        SETTLE,
        LOCKED
    } state_t;

    // Returns {is_token, ctrl}.
    function automatic logic [2:0] token_lookup(input logic [9:0] s);
        logic [2:0] r;
        unique case (1'b1)
            (s == TOK_00): r = 3'b1_00;
            (s == TOK_01): r = 3'b1_01;
            (s == TOK_10): r = 3'b1_10;
            (s == TOK_11): r = 3'b1_11;
            default:       r = 3'b0_00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token detect plus
// inversion / transition-minimised data recovery.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_token,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    logic [7:0] d;

    always_comb begin
        {is_token, ctrl} = token_lookup(sym);
    end

    always_comb begin
        d = sym[9] ? ~sym[7:0] : sym[7:0];
        data = '0;
        data[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            data[i] = sym[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
        end
    end

endmodule

// File: rtl/tmds_channel_decoder.sv
// One TMDS data channel receiver: bit-offset word alignment on control-token runs and decode.
// Define TMDS_ERRCNT_EN to add the err_cnt port counting encoder-rule violations.
module tmds_channel_decoder
    import tmds_pkg::*;
#(
    parameter int TOKEN_RUN      = 8,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int LOSS_TIMEOUT   = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  sym_in,
    output logic [7:0]  data_out,
    output logic [1:0]  ctrl_out,
    output logic        de_out,
    output logic        locked,
    output logic [3:0]  bit_offset
`ifdef TMDS_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int TMAX = (SEARCH_TIMEOUT > LOSS_TIMEOUT) ? SEARCH_TIMEOUT : LOSS_TIMEOUT;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int RW   = $clog2(TOKEN_RUN + 1);
    localparam logic [TW-1:0] SEARCH_LAST = TW'(SEARCH_TIMEOUT - 1);
    localparam logic [TW-1:0] LOSS_LAST   = TW'(LOSS_TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_FULL    = RW'(TOKEN_RUN);

    state_t        state;
    state_t        state_nxt;
    logic [9:0]    sym_d;
    logic [9:0]    aligned_q;
    logic [19:0]   win;
    logic [TW-1:0] timer;
    logic [RW-1:0] run;
    logic [RW-1:0] run_nxt;
    logic          settle_cnt;
    logic [3:0]    offset;
    logic          tok;
    logic [1:0]    tok_ctrl;
    logic [7:0]    dec;
    logic          hit;
    logic          search_to;
    logic          loss_to;
    logic          slip;
    logic          drop;
    logic [7:0]    data_q;
    logic [1:0]    ctrl_q;
    logic          de_q;

    // Older symbol sits in the low half so offset 0 selects sym_d.
    assign win = {sym_in, sym_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_d     <= '0;
            aligned_q <= '0;
        end else begin
            sym_d     <= sym_in;
            aligned_q <= win[{1'b0, offset} +: 10];
        end
    end

    tmds_symbol_decode u_dec (
        .sym      (aligned_q),
        .is_token (tok),
        .ctrl     (tok_ctrl),
        .data     (dec)
    );

    always_comb begin
        run_nxt = '0;
        if (state != SETTLE && tok) begin
            run_nxt = (run == RUN_FULL) ? run : run + 1'b1;
        end
    end

    // A run completing on the timeout cycle takes priority over slip / loss.
    assign hit       = (run_nxt == RUN_FULL);
    assign search_to = (state == SEARCH) && (timer == SEARCH_LAST);
    assign loss_to   = (state == LOCKED) && (timer == LOSS_LAST);
    assign slip      = search_to && !hit;
    assign drop      = loss_to && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEARCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            SEARCH: begin
                if (hit) begin
                    state_nxt = LOCKED;
                end else if (search_to) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt) begin
                    state_nxt = SEARCH;
                end
            end
            LOCKED: begin
                if (drop) begin
                    state_nxt = SEARCH;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer      <= '0;
            run        <= '0;
            settle_cnt <= 1'b0;
            offset     <= 4'd0;
        end else begin
            run        <= (slip || drop) ? '0 : run_nxt;
            settle_cnt <= (state == SETTLE) && !settle_cnt;
            if (state == SETTLE || hit || slip || drop) begin
                timer <= '0;
            end else begin
                timer <= timer + 1'b1;
            end
            if (slip) begin
                offset <= (offset == 4'd9) ? 4'd0 : offset + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            ctrl_q <= '0;
            de_q   <= 1'b0;
        end else if (tok) begin
            de_q   <= 1'b0;
            ctrl_q <= tok_ctrl;
        end else begin
            de_q   <= 1'b1;
            data_q <= dec;
        end
    end

    always_comb begin
        locked     = (state == LOCKED);
        bit_offset = offset;
        data_out   = locked ? data_q : '0;
        ctrl_out   = locked ? ctrl_q : '0;
        de_out     = locked & de_q;
    end

`ifdef TMDS_ERRCNT_EN
    logic        use_xnor;
    logic        sym_bad;
    logic [15:0] err_q;

    // The encoder picks XNOR (q[8]=0) for ones>4, or ones==4 with bit 0 clear.
    always_comb begin
        use_xnor = ($countones(dec) > 4) || ($countones(dec) == 4 && !dec[0]);
        sym_bad  = (use_xnor == aligned_q[8]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (state == LOCKED && !tok && sym_bad && err_q != 16'hFFFF) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_cnt = err_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Bench for tmds_channel_decoder: bitstream-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tmds_channel_decoder;

    localparam int TR = 8;
    localparam int ST = 64;
    localparam int LT = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] sym_in = '0;
    logic [7:0] data_out;
    logic [1:0] ctrl_out;
    logic       de_out;
    logic       locked;
    logic [3:0] bit_offset;
`ifdef TMDS_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    tmds_channel_decoder #(
        .TOKEN_RUN      (TR),
        .SEARCH_TIMEOUT (ST),
        .LOSS_TIMEOUT   (LT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sym_in     (sym_in),
        .data_out   (data_out),
        .ctrl_out   (ctrl_out),
        .de_out     (de_out),
        .locked     (locked),
        .bit_offset (bit_offset)
`ifdef TMDS_ERRCNT_EN
        ,
        .err_cnt    (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: bitstream window, lock flag, quiet-cycle count.
    int m_symd = 0, m_al = 0, m_off = 0, m_quiet = 0, m_run = 0;
    int m_settle_left = 0, m_data = 0, m_ctrl = 0, m_de = 0, m_err = 0;
    bit m_lk = 0, m_settling = 0;

    function automatic int tok_code(input int s);
        case (s)
            'h354:   return 0;
            'h0AB:   return 1;
            'h154:   return 2;
            'h2AB:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic int decode(input int q);
        int d, o, b;
        d = ((q >> 9) & 1) ? (~q & 255) : (q & 255);
        o = d & 1;
        for (int i = 1; i < 8; i++) begin
            b = ((d >> i) ^ (d >> (i - 1))) & 1;
            if (((q >> 8) & 1) == 0) b = b ^ 1;
            o = o | (b << i);
        end
        return o;
    endfunction

    function automatic bit bad_sym(input int q);
        int o, n;
        bit x;
        o = decode(q);
        n = 0;
        for (int i = 0; i < 8; i++) n += (o >> i) & 1;
        x = (n > 4) || (n == 4 && (o & 1) == 0);
        return x == (((q >> 8) & 1) == 1);
    endfunction

    task automatic model_reset();
        m_symd = 0; m_al = 0; m_off = 0; m_quiet = 0; m_run = 0;
        m_settle_left = 0; m_data = 0; m_ctrl = 0; m_de = 0; m_err = 0;
        m_lk = 0; m_settling = 0;
    endtask

    task automatic model_step(input int s);
        int nal, code, rnew;
        bit tok, full;
        nal = (((s << 10) | m_symd) >> m_off) & 'h3FF;
        code = tok_code(m_al);
        tok = (code >= 0);
        if (tok) begin
            m_de = 0;
            m_ctrl = code;
        end else begin
            m_de = 1;
            m_data = decode(m_al);
        end
        if (m_lk && !tok && bad_sym(m_al) && m_err < 65535) m_err++;
        rnew = (!m_settling && tok) ? ((m_run < TR) ? m_run + 1 : TR) : 0;
        full = (rnew == TR);
        if (m_settling) begin
            m_settle_left--;
            if (m_settle_left == 0) m_settling = 0;
            m_quiet = 0;
            m_run = 0;
        end else if (full) begin
            m_lk = 1;
            m_quiet = 0;
            m_run = rnew;
        end else if (m_quiet == (m_lk ? LT : ST) - 1) begin
            if (m_lk) begin
                m_lk = 0;
            end else begin
                m_off = (m_off + 1) % 10;
                m_settling = 1;
                m_settle_left = 2;
            end
            m_quiet = 0;
            m_run = 0;
        end else begin
            m_quiet++;
            m_run = rnew;
        end
        m_al = nal;
        m_symd = s;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step(int'(sym_in));
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        logic [7:0] ed;
        logic [1:0] ec;
        logic       ede, elk;
        logic [3:0] eoff;
        @(negedge clk);
        ed   = m_lk ? 8'(m_data) : 8'h00;
        ec   = m_lk ? 2'(m_ctrl) : 2'b00;
        ede  = m_lk && (m_de != 0);
        elk  = m_lk;
        eoff = 4'(m_off);
        checks++;
        if ({data_out, ctrl_out, de_out, locked, bit_offset} !== {ed, ec, ede, elk, eoff}) begin
            errors++;
            $display("FAIL model_cmp t=%0t got d=%h c=%0d de=%0b lk=%0b off=%0d need d=%h c=%0d de=%0b lk=%0b off=%0d",
                     $time, data_out, ctrl_out, de_out, locked, bit_offset, ed, ec, ede, elk, eoff);
        end
`ifdef TMDS_ERRCNT_EN
        checks++;
        if (err_cnt !== 16'(m_err)) begin
            errors++;
            $display("FAIL model_err t=%0t got %0d need %0d", $time, err_cnt, m_err);
        end
`endif
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d need %0d", name, got, exp);
        end
    endtask

    task automatic send(input logic [9:0] s);
        sym_in = s;
        @(posedge clk);
        #2;
    endtask

    task automatic send_n(input logic [9:0] s, input int n);
        for (int i = 0; i < n; i++) send(s);
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        sym_in = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        bit done;
        int nlock;
        logic [9:0] pat, prev;
        logic [3:0] last_off;
        int chg[$];

        // Power-on reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_locked", locked, 0);
        chk("rst_offset", bit_offset, 0);
        chk("rst_de", de_out, 0);
        chk("rst_data", data_out, 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Aligned stream at offset 0: token run then data 0x00 / 0xFF
        send_n(10'h354, 12);
        send(10'h100);
        @(negedge clk);
        chk("t2_locked", locked, 1);
        chk("t2_de_ctrl", de_out, 0);
        chk("t2_ctrl", ctrl_out, 0);
        send(10'h200);
        sym_in = 10'h354;
        @(posedge clk);
        @(negedge clk);
        chk("t2_data00", data_out, 8'h00);
        chk("t2_de_data", de_out, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t2_dataff", data_out, 8'hFF);

        // Lock loss: 2 pipeline edges plus 64 quiet cycles after the last token
        send_n(10'h354, 10);
        sym_in = 10'h100;
        n = 0;
        done = 0;
        while (n < 200 && !done) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (!locked) done = 1;
        end
        chk("t5_loss_latency", n, 66);
        chk("t5_forced_de", de_out, 0);
        chk("t5_forced_data", data_out, 0);

`ifdef TMDS_ERRCNT_EN
        send_n(10'h354, 10);
        chk("t6_err_before", err_cnt, 0);
        send(10'h155);
        send(10'h100);
        sym_in = 10'h354;
        @(posedge clk);
        @(negedge clk);
        chk("t6_data_ff", data_out, 8'hFF);
        chk("t6_err_one", err_cnt, 1);
        @(posedge clk);
        @(negedge clk);
        chk("t6_data_00", data_out, 8'h00);
        chk("t6_err_held", err_cnt, 1);
`endif

        // Stream delayed by 3 bits: offset must walk 0,1,2,3 then lock
        reset_pulse();
        prev = '0;
        last_off = bit_offset;
        done = 0;
        for (int k = 0; k < 600 && !done; k++) begin
            pat = ((k % 48) < 8) ? 10'h2AB : 10'h100;
            send({pat[6:0], prev[9:7]});
            prev = pat;
            if (bit_offset != last_off) begin
                chg.push_back(k);
                last_off = bit_offset;
            end
            if (locked) begin
                done = 1;
                chk("t3_lock_ctrl", ctrl_out, 3);
                chk("t3_lock_de", de_out, 0);
            end
        end
        chk("t3_locked", done, 1);
        chk("t3_offset", bit_offset, 3);
        chk("t3_nslips", chg.size(), 3);
        chk("t3_first_slip", (chg.size() > 0) ? chg[0] : -1, 63);
        chk("t3_interval1", (chg.size() > 1) ? chg[1] - chg[0] : -1, 66);
        chk("t3_interval2", (chg.size() > 2) ? chg[2] - chg[1] : -1, 66);

        // Mid-stream reset clears everything at once
        rst_n = 1'b0;
        #1;
        chk("t1_locked", locked, 0);
        chk("t1_offset", bit_offset, 0);
        chk("t1_de", de_out, 0);
        chk("t1_ctrl", ctrl_out, 0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Runs of 7 tokens never lock; offset keeps advancing
        nlock = 0;
        chg.delete();
        last_off = bit_offset;
        for (int k = 0; k < 400; k++) begin
            send(((k % 12) < 7) ? 10'h0AB : 10'h100);
            if (locked) nlock++;
            if (bit_offset != last_off) begin
                chg.push_back(k);
                last_off = bit_offset;
            end
        end
        chk("t4_never_locked", nlock, 0);
        chk("t4_nslips", chg.size(), 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
